// File: rtl/uart_tx_frame_sequencer.sv
// UART transmit frame sequencer: paces start/data/parity/stop bits from an
// oversample tick enable using a frame format snapshotted at accept.
module uart_tx_frame_sequencer #(
  parameter int unsigned TICKS_A = 16,
  parameter int unsigned TICKS_B = 13
) (
  input  logic       m_clk,
  input  logic       reset,
  input  logic       baud_en,
  input  logic       osm_sel,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int unsigned TICK_W = 4;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP_EXT
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        data_q;
  logic [1:0]        wls_q;
  logic              stb_q, pen_q, eps_q, sp_q, osm_q;
  logic              txd_q, ready_q, busy_q, done_q;

  logic [LEN_W-1:0]  full_len_c, cur_len_c;
  logic [7:0]        data_m_c;
  logic              accept_c, bit_end_c, last_bit_c, par_c, txd_d, done_d;

  // Next-state, counters and next txd level
  always_comb begin
    state_d    = state_q;
    tick_d     = baud_en ? tick_q + TICK_W'(1) : tick_q;
    bit_d      = bit_q;
    done_d     = 1'b0;
    txd_d      = 1'b1;

    accept_c   = (state_q == S_IDLE) && tx_valid && ready_q;
    full_len_c = osm_q ? LEN_W'(TICKS_B) : LEN_W'(TICKS_A);
    // 1.5 stop bits only for 5-bit words: extension is ceil(N/2)
    cur_len_c  = (state_q == S_STOP_EXT && wls_q == 2'b00)
                 ? LEN_W'((full_len_c + LEN_W'(1)) >> 1) : full_len_c;
    bit_end_c  = baud_en && (tick_q == TICK_W'(cur_len_c - LEN_W'(1)));
    last_bit_c = (bit_q == BIT_W'(wls_q) + BIT_W'(4));
    data_m_c   = data_q & ~(8'he0 << wls_q);
    par_c      = sp_q ? ~eps_q : (eps_q ? ^data_m_c : ~^data_m_c);

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (accept_c) begin
          state_d = S_START;
          bit_d   = '0;
        end
      end
      S_START: if (bit_end_c) begin
        tick_d  = '0;
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (bit_end_c) begin
        tick_d = '0;
        if (last_bit_c) state_d = pen_q ? S_PARITY : S_STOP;
        else            bit_d   = bit_q + BIT_W'(1);
      end
      S_PARITY: if (bit_end_c) begin
        tick_d  = '0;
        state_d = S_STOP;
      end
      S_STOP: if (bit_end_c) begin
        tick_d = '0;
        if (stb_q) state_d = S_STOP_EXT;
        else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_STOP_EXT: if (bit_end_c) begin
        tick_d  = '0;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_q[bit_d];
      S_PARITY: txd_d = par_c;
      default:  txd_d = 1'b1;
    endcase
    if (BC) txd_d = 1'b0;
  end

  // State, counters, snapshot and registered outputs
  always_ff @(posedge m_clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sp_q    <= 1'b0;
      osm_q   <= 1'b0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      if (accept_c) begin
        data_q <= tx_data;
        wls_q  <= WLS;
        stb_q  <= STB;
        pen_q  <= PEN;
        eps_q  <= EPS;
        sp_q   <= SP;
        osm_q  <= osm_sel;
      end
    end
  end

  assign tx_ready   = ready_q;
  assign txd        = txd_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Directed bench for uart_tx_frame_sequencer: checks per-cycle txd, handshake
// and frame_done against hand-computed frame bit patterns.
module tb_uart_tx_frame_sequencer;

  logic       m_clk = 1'b0;
  logic       reset;
  logic       baud_en;
  logic       osm_sel;
  logic [1:0] WLS;
  logic       STB, PEN, EPS, SP, BC;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, txd, tx_busy, frame_done;

  int tests = 0;
  int fails = 0;

  uart_tx_frame_sequencer #(.TICKS_A(16), .TICKS_B(13)) dut (
    .m_clk(m_clk), .reset(reset), .baud_en(baud_en), .osm_sel(osm_sel),
    .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .BC(BC),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .txd(txd), .tx_busy(tx_busy), .frame_done(frame_done)
  );

  always #5 m_clk = ~m_clk;

  task automatic chk(input logic got, input logic exp, input string tag, input int j);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, j, got, exp);
    end
  endtask

  // Handshake one byte; returns at the first sample point after the accept edge
  task automatic accept_byte(input logic [7:0] d, input string tag);
    chk(tx_ready, 1'b1, {tag, "_ready_pre"}, -1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge m_clk);
    tx_valid = 1'b0;
  endtask

  // Segment i of the frame has level bits[i]; all segments are n ticks except the last
  task automatic run_frame(input logic [11:0] bits, input int nseg, input int n,
                           input int last_len, input int chg_at, input int brk_at,
                           input string tag);
    int   total;
    int   idx;
    logic exp_txd;
    total = (nseg - 1) * n + last_len;
    for (int j = 0; j <= total + 1; j++) begin
      idx = j / n;
      if (idx > nseg - 1) idx = nseg - 1;
      exp_txd = (j >= total) ? 1'b1 : bits[idx];
      if (brk_at >= 0 && j > brk_at) exp_txd = 1'b0;
      chk(txd,        exp_txd,          {tag, "_txd"},   j);
      chk(frame_done, (j == total),     {tag, "_done"},  j);
      chk(tx_ready,   (j >= total),     {tag, "_ready"}, j);
      chk(tx_busy,    (j < total),      {tag, "_busy"},  j);
      if (j == chg_at) begin
        WLS = 2'b00;
        EPS = 1'b1;
      end
      if (j == brk_at) BC = 1'b1;
      @(negedge m_clk);
    end
  endtask

  initial begin
    reset = 1'b0; baud_en = 1'b1; osm_sel = 1'b0; WLS = 2'b11; STB = 1'b0;
    PEN = 1'b0; EPS = 1'b0; SP = 1'b0; BC = 1'b0; tx_data = 8'h00; tx_valid = 1'b1;
    repeat (2) @(negedge m_clk);
    chk(txd, 1'b1, "rst_txd", 0);
    chk(tx_ready, 1'b1, "rst_ready", 0);
    chk(tx_busy, 1'b0, "rst_busy", 0);
    chk(frame_done, 1'b0, "rst_done", 0);
    tx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge m_clk);

    // 8N1 0x55
    accept_byte(8'h55, "8n1");
    run_frame(12'h2AA, 10, 16, 16, -1, -1, "8n1");

    // 7E1 0x83: bit 7 ignored, two ones -> even parity 0
    WLS = 2'b10; PEN = 1'b1; EPS = 1'b1;
    accept_byte(8'h83, "7e1");
    run_frame(12'h206, 10, 16, 16, -1, -1, "7e1");

    // 7O1 0x83 -> parity 1
    EPS = 1'b0;
    accept_byte(8'h83, "7o1");
    run_frame(12'h306, 10, 16, 16, -1, -1, "7o1");

    // 5 bits, 1.5 stop, osm 13: stop 13+7
    WLS = 2'b00; PEN = 1'b0; STB = 1'b1; osm_sel = 1'b1;
    accept_byte(8'h1F, "5n15");
    run_frame(12'h0FE, 8, 13, 7, -1, -1, "5n15");

    // 8 bits, 2 stop, osm 13: stop 26
    WLS = 2'b11;
    accept_byte(8'hA5, "8n2");
    run_frame(12'h74A, 11, 13, 13, -1, -1, "8n2");

    // Stick parity 1 on 0x00, format changed mid-frame
    STB = 1'b0; osm_sel = 1'b0; PEN = 1'b1; SP = 1'b1; EPS = 1'b0;
    accept_byte(8'h00, "stick");
    run_frame(12'h600, 11, 16, 16, 20, -1, "stick");

    // Break raised during data
    WLS = 2'b11; PEN = 1'b0; SP = 1'b0; EPS = 1'b0;
    accept_byte(8'h55, "brk");
    run_frame(12'h2AA, 10, 16, 16, -1, 40, "brk");
    chk(txd, 1'b0, "brk_hold", 0);
    BC = 1'b0;
    @(negedge m_clk);
    chk(txd, 1'b1, "brk_release", 0);

    // Ticks held while baud_en is low
    baud_en = 1'b0;
    accept_byte(8'hC3, "gap");
    for (int k = 0; k < 20; k++) begin
      chk(tx_busy, 1'b1, "gap_busy", k);
      chk(txd, 1'b0, "gap_txd", k);
      chk(tx_ready, 1'b0, "gap_ready", k);
      @(negedge m_clk);
    end
    baud_en = 1'b1;
    run_frame(12'h386, 10, 16, 16, -1, -1, "gap");

    // Reset mid-frame, valid ignored during reset
    accept_byte(8'h55, "rstmid");
    repeat (40) @(negedge m_clk);
    chk(tx_busy, 1'b1, "rstmid_busy_pre", 40);
    reset = 1'b0; tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge m_clk);
    chk(txd, 1'b1, "rstmid_txd", 0);
    chk(tx_ready, 1'b1, "rstmid_ready", 0);
    chk(tx_busy, 1'b0, "rstmid_busy", 0);
    chk(frame_done, 1'b0, "rstmid_done", 0);
    reset = 1'b1; tx_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      chk(frame_done, 1'b0, "rstmid_nodone", k);
      chk(tx_busy, 1'b0, "rstmid_idle", k);
      @(negedge m_clk);
    end
    accept_byte(8'h55, "after_rst");
    run_frame(12'h2AA, 10, 16, 16, -1, -1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
